// File: rtl/regfile_mp.sv
// ============================================================================
// Module   : regfile_mp
// Brief    : Multi-port register file with per-register busy scoreboard.
//            Optional write-first bypass enabled by macro REGFILE_MP_BYPASS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_mp #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]    rd_busy_o,
  input  logic              iss_en_i,
  input  logic [AW-1:0]     iss_addr_i,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [XLEN-1:0]   wr_data_i,
  input  logic              wr_clr_i
);

  localparam logic [AW-1:0] C_ZERO_ADDR = '0;

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;
  logic            w_wr_ok;
  logic            w_clr_ok;
  logic            w_iss_ok;

  assign w_wr_ok  = wr_en_i && (wr_addr_i != C_ZERO_ADDR);
  assign w_clr_ok = w_wr_ok && wr_clr_i;
  assign w_iss_ok = iss_en_i && (iss_addr_i != C_ZERO_ADDR);

  // Set is applied after clear so a younger issue keeps ownership.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_clr_ok) w_busy_nxt[wr_addr_i] = 1'b0;
    if (w_iss_ok) w_busy_nxt[iss_addr_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_busy <= '0;
    end else begin
      if (w_wr_ok) r_regs[wr_addr_i] <= wr_data_i;
      r_busy <= w_busy_nxt;
    end
  end

  generate
    for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   w_addr;
      logic [XLEN-1:0] w_data;
      logic            w_busy;

      assign w_addr = rd_addr_i[k*AW +: AW];

      always_comb begin
        w_data = r_regs[w_addr];
        w_busy = r_busy[w_addr];
`ifdef REGFILE_MP_BYPASS_EN
        if (w_wr_ok && (w_addr == wr_addr_i)) begin
          w_data = wr_data_i;
          if (wr_clr_i) w_busy = w_iss_ok && (iss_addr_i == w_addr);
        end
`endif
        // Register 0 is hardwired regardless of stored or bypassed state.
        if (w_addr == C_ZERO_ADDR) begin
          w_data = '0;
          w_busy = 1'b0;
        end
      end

      assign rd_data_o[k*XLEN +: XLEN] = w_data;
      assign rd_busy_o[k]              = w_busy;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus pushes model expectations,
// a negedge monitor pops and compares them against the read ports.
`default_nettype none

module tb_regfile_mp;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NRD*AW-1:0] rd_addr_i;
  logic [NRD*XLEN-1:0] rd_data_o;
  logic [NRD-1:0]    rd_busy_o;
  logic              iss_en_i;
  logic [AW-1:0]     iss_addr_i;
  logic              wr_en_i;
  logic [AW-1:0]     wr_addr_i;
  logic [XLEN-1:0]   wr_data_i;
  logic              wr_clr_i;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk(clk), .rst(rst),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .rd_busy_o(rd_busy_o),
    .iss_en_i(iss_en_i), .iss_addr_i(iss_addr_i),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .wr_clr_i(wr_clr_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [4:0]  addr;
    logic [63:0] data;
    logic        busy;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] m_regs [NREG];
  bit          m_busy [NREG];
  int          checks = 0;
  int          errors = 0;

  // Architectural view of a read, including same-cycle bypass when built in.
  function automatic exp_t predict(int port, logic [4:0] a);
    exp_t e;
    e.port = port;
    e.addr = a;
    e.data = m_regs[a];
    e.busy = m_busy[a];
`ifdef REGFILE_MP_BYPASS_EN
    if (wr_en_i && wr_addr_i != 0 && wr_addr_i == a) begin
      e.data = wr_data_i;
      if (wr_clr_i) e.busy = iss_en_i && iss_addr_i == a;
    end
`endif
    if (a == 0) begin
      e.data = 64'd0;
      e.busy = 1'b0;
    end
    return e;
  endfunction

  task automatic cycle(input bit r, input bit we, input logic [4:0] wa,
                       input logic [63:0] wd, input bit wc, input bit ie,
                       input logic [4:0] ia, input logic [4:0] a0,
                       input logic [4:0] a1, input bit chk);
    rst = r; wr_en_i = we; wr_addr_i = wa; wr_data_i = wd; wr_clr_i = wc;
    iss_en_i = ie; iss_addr_i = ia;
    rd_addr_i[0 +: AW] = a0;
    rd_addr_i[AW +: AW] = a1;
    if (chk) begin
      exp_q.push_back(predict(0, a0));
      exp_q.push_back(predict(1, a1));
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < NREG; i++) begin
        m_regs[i] = 64'd0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (we && wa != 0) m_regs[wa] = wd;
      if (we && wc && wa != 0) m_busy[wa] = 1'b0;
      if (ie && ia != 0) m_busy[ia] = 1'b1;
    end
    #1;
  endtask

  task automatic idle_read(input logic [4:0] a0, input logic [4:0] a1);
    cycle(0, 0, 0, 0, 0, 0, 0, a0, a1, 1);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [63:0] d;
      logic        b;
      e = exp_q.pop_front();
      d = rd_data_o[e.port*XLEN +: XLEN];
      b = rd_busy_o[e.port];
      checks++;
      if (d !== e.data || b !== e.busy) begin
        errors++;
        $display("FAIL read p%0d r%0d: got data=%h busy=%b, want data=%h busy=%b",
                 e.port, e.addr, d, b, e.data, e.busy);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] a, b, w, ii;
    rd_addr_i = '0;
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = 64'd0;
      m_busy[i] = 1'b0;
    end
    @(posedge clk); #1;
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Reset: data written before reset and during the reset cycle are lost.
    cycle(0, 1, 5, 64'hDEAD, 0, 1, 5, 5, 0, 1);
    idle_read(5, 5);
    cycle(1, 1, 7, 64'h1234, 0, 1, 7, 0, 0, 0);
    for (int i = 0; i < NREG; i += 2) idle_read(i[4:0], 5'(i + 1));
    // Register 0 discipline.
    cycle(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0, 0, 0, 1);
    idle_read(0, 0);
    // Write/read and duplicate ports.
    cycle(0, 1, 3, 64'h11, 0, 0, 0, 3, 4, 1);
    cycle(0, 1, 4, 64'h22, 0, 0, 0, 3, 4, 1);
    idle_read(3, 4);
    idle_read(4, 4);
    // Scoreboard set, then clear on write-back.
    cycle(0, 0, 0, 0, 0, 1, 9, 9, 9, 1);
    idle_read(9, 0);
    cycle(0, 1, 9, 64'h55, 1, 0, 0, 9, 9, 1);
    idle_read(9, 9);
    // Same-cycle issue and clear: set wins.
    cycle(0, 0, 0, 0, 0, 1, 9, 9, 0, 1);
    cycle(0, 1, 9, 64'h77, 1, 1, 9, 9, 9, 1);
    idle_read(9, 9);
    // Same-cycle read of a register being written back.
    cycle(0, 0, 0, 0, 0, 1, 6, 6, 6, 1);
    cycle(0, 1, 6, 64'hAB, 1, 0, 0, 6, 6, 1);
    idle_read(6, 6);
    // Randomized traffic, addresses biased to a small set to force collisions.
    for (int n = 0; n < 400; n++) begin
      a  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      b  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      w  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      ii = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      cycle($urandom_range(0, 49) == 0, $urandom_range(0, 1) != 0, w,
            {$urandom, $urandom}, $urandom_range(0, 1) != 0,
            $urandom_range(0, 1) != 0, ii, a, b, 1);
    end
    idle_read(1, 2);
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the pipelined core, with a per-register scoreboard (busy bits). It serves NRD combinational read ports for the decode stage and one write-back port. Issue marks a destination busy; write-back clears it, so decode can detect RAW hazards without a separate tracker. Register 0 is hardwired to zero, and the block resets synchronously to an all-zero, all-idle state.

## Interface
Parameters:
- XLEN, 64: data width in bits.
- NREG, 32: number of architectural registers; power of two, ≥2.
- NRD, 2: number of read ports, 1..4.
- AW, $clog2(NREG): register address width (derived, not overridden).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- rd_addr_i  in  NRD*AW  read addresses, packed; port k at [k*AW +: AW].
- rd_data_o  out  NRD*XLEN  read data, packed likewise.
- rd_busy_o  out  NRD  per-port busy flag of the addressed register.
- iss_en_i  in  1  issue strobe; marks iss_addr_i busy.
- iss_addr_i  in  AW  destination register of the issuing instruction.
- wr_en_i  in  1  write-back strobe.
- wr_addr_i  in  AW  write-back register.
- wr_data_i  in  XLEN  write-back data.
- wr_clr_i  in  1  when high with wr_en_i, clear the busy bit of wr_addr_i.

## Operation
- Storage: NREG×XLEN data array plus NREG busy bits.
- Reset (rst high at posedge): every data word is set to 0 and every busy bit is cleared. All writes and issues in that cycle are ignored.
- Write: at posedge with wr_en_i=1 and wr_addr_i≠0, regs[wr_addr_i] ← wr_data_i. When wr_en_i=0, the array holds.
- Busy set: at posedge with iss_en_i=1 and iss_addr_i≠0, busy[iss_addr_i] ← 1.
- Busy clear: at posedge with wr_en_i=1, wr_clr_i=1 and wr_addr_i≠0, busy[wr_addr_i] ← 0.
- Simultaneous set and clear on the same register: the set wins, and busy stays 1 because a younger instruction now owns it. The data write still occurs.
- Register 0: reads always return 0 with busy 0. Writes and issues to register 0 are discarded.
- Read, per port k: rd_data_o[k] = regs[addr_k] and rd_busy_o[k] = busy[addr_k], combinational from the current state, subject to the bypass rule below.
- Reads on different ports are independent. Duplicate addresses on several ports return identical values.

## Timing
- Write latency: data is visible on the read ports from the cycle after the write posedge. Same-cycle visibility depends on the Configuration macro.
- Busy latency: the set is visible from the cycle after the issue posedge.
- Read latency: 0 cycles, purely combinational from the address.
- Output reset values: after the reset posedge, every rd_data_o word is 0 and every rd_busy_o bit is 0 for any address.
- Reset asserted mid-operation overrides any pending write or issue in that cycle. There is no partial state.
- No handshake or back-pressure: each strobe is accepted on every posedge it is high, outside reset.

## Configuration
- Macro REGFILE_MP_BYPASS_EN.
- Defined: write-first bypass. When wr_en_i=1, wr_addr_i≠0 and rd_addr_k==wr_addr_i in the same cycle:
  - rd_data_o[k] = wr_data_i.
  - rd_busy_o[k] = 0 if wr_clr_i=1, unless iss_en_i=1 with iss_addr_i==rd_addr_k, in which case rd_busy_o[k] = 1.
- Not defined: no bypass. Reads return stored state only. Written data and busy clears appear one cycle after the write posedge.

## Test plan
- Reset: write 0xDEAD to r5, then assert rst for 1 cycle → all read ports show data 0 and busy 0 for r0..r31. A write of 0x1234 to r7 issued during the reset cycle is lost, and r7 reads 0.
- r0 discipline: write 0xFFFF_FFFF_FFFF_FFFF to r0 and issue to r0 → r0 reads 0 with busy 0 on all ports.
- Write/read plus multi-port: write r3=0x11, r4=0x22 on successive cycles. Next cycle, port0=r3 and port1=r4 → 0x11 and 0x22. Both ports set to r4 → 0x22 on both.
- Scoreboard: issue r9, then next cycle busy for r9=1. Write-back r9=0x55 with wr_clr_i=1 → busy=0 and data=0x55 the following cycle.
- Same-cycle issue and clear on r9 → busy remains 1 and data updates to the written value.
- Bypass, same cycle: write r6=0xAB with wr_clr_i=1 while port0 reads r6 (r6 busy, old value 0). With REGFILE_MP_BYPASS_EN: port0 shows 0xAB and busy 0 in that cycle. Without it: port0 shows 0 and busy 1, then 0xAB and busy 0 the next cycle.
